// File: rtl/dmem_pkg.sv
// dmem_pkg: width encodings, FSM state type and misalignment rule for data_mem
package dmem_pkg;

   localparam logic [1:0] WIDTH_B = 2'b00;
   localparam logic [1:0] WIDTH_H = 2'b01;
   localparam logic [1:0] WIDTH_W = 2'b10;

   typedef enum logic {ST_IDLE, ST_WAIT} state_t;

   // halfwords need an even address, words (including the reserved encoding) a multiple of four
   function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lo);
      return (width == WIDTH_B) ? 1'b0 : (width == WIDTH_H) ? lo[0] : (lo != 2'b00);
   endfunction

endpackage

// File: rtl/dmem_align.sv
// dmem_align: byte-lane enables, store replication and load extraction/extension
module dmem_align
   import dmem_pkg::*;
(
   input  logic [1:0]  i_width,
   input  logic [1:0]  i_lane,
   input  logic        i_extend,
   input  logic [31:0] i_store,
   input  logic [31:0] i_word,
   output logic [3:0]  o_be,
   output logic [31:0] o_store,
   output logic [31:0] o_load
);
   logic [31:0] w_shift;
   logic [15:0] w_half;
   logic [7:0]  w_byte;

   // lane selection follows little-endian order; misaligned low bits are masked by the lane choice
   always_comb begin
      w_shift = i_word >> {i_lane, 3'b000};
      w_byte  = w_shift[7:0];
      w_half  = i_lane[1] ? i_word[31:16] : i_word[15:0];
      o_be    = (i_width == WIDTH_B) ? (4'b0001 << i_lane) :
                (i_width == WIDTH_H) ? (i_lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      o_store = (i_width == WIDTH_B) ? {4{i_store[7:0]}} :
                (i_width == WIDTH_H) ? {2{i_store[15:0]}} : i_store;
      o_load  = (i_width == WIDTH_B) ? {{24{i_extend & w_byte[7]}}, w_byte} :
                (i_width == WIDTH_H) ? {{16{i_extend & w_half[15]}}, w_half} : i_word;
   end

endmodule

// File: rtl/data_mem.sv
// data_mem: data-side load/store responder with wait states; DMEM_MISALIGN_CHECK_EN enables misalignment faults
module data_mem
   import dmem_pkg::*;
#(
   parameter int ADDR_BITS   = 12,
   parameter int WAIT_STATES = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   input  logic        i_write,
   input  logic [31:0] i_data_out,
   input  logic        i_extend,
   input  logic [1:0]  i_width,
   output logic        o_ack,
   output logic [31:0] o_data_in,
   output logic        o_fault
);
   state_t               r_state, w_state_nxt;
   logic [3:0]           r_cnt, w_cnt_nxt;
   logic [31:0]          r_mem [2**ADDR_BITS];
   logic [31:0]          r_data_in;
   logic [ADDR_BITS-1:0] w_idx;
   logic [3:0]           w_be;
   logic [31:0]          w_wdata, w_rword, w_rdata;
   logic                 w_bad, w_we, w_ld;
   logic                 w_unused;

   assign w_idx    = i_addr[ADDR_BITS+1:2];
   assign w_unused = ^i_addr[31:ADDR_BITS+2];
   assign w_rword  = r_mem[w_idx];

`ifdef DMEM_MISALIGN_CHECK_EN
   assign w_bad = misaligned(i_width, i_addr[1:0]);
`else
   assign w_bad = 1'b0;
`endif

   assign o_fault   = o_ack & w_bad;
   assign w_we      = o_ack & i_write & ~w_bad;
   assign w_ld      = o_ack & ~i_write & ~w_bad;
   assign o_data_in = r_data_in;

   dmem_align u_align (
      .i_width  (i_width),
      .i_lane   (i_addr[1:0]),
      .i_extend (i_extend),
      .i_store  (i_data_out),
      .i_word   (w_rword),
      .o_be     (w_be),
      .o_store  (w_wdata),
      .o_load   (w_rdata)
   );

   // next state, wait countdown and ack; ack is held low while reset is asserted
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_ack       = 1'b0;
      if (r_state == ST_IDLE) begin
         if (i_req && WAIT_STATES == 0) o_ack = 1'b1;
         else if (i_req) begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = 4'(WAIT_STATES - 1);
         end
      end else if (!i_req) w_state_nxt = ST_IDLE;
      else if (r_cnt == 4'd0) begin
         o_ack       = 1'b1;
         w_state_nxt = ST_IDLE;
      end else w_cnt_nxt = r_cnt - 4'd1;
      o_ack = o_ack & reset_n;
   end

   // FSM state and wait counter registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // load result register, updated only by a completed aligned load
   always_ff @(posedge clk) begin
      if (!reset_n) r_data_in <= 32'd0;
      else if (w_ld) r_data_in <= w_rdata;
   end

   // commit enabled store lanes at the end of the ack cycle
   always_ff @(posedge clk) begin
      if (w_we)
         for (int b = 0; b < 4; b++)
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
   end

endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: table vectors, random model comparison and wait-state sequences for data_mem
module tb_data_mem;
`ifdef DMEM_MISALIGN_CHECK_EN
   localparam logic M = 1'b1;
`else
   localparam logic M = 1'b0;
`endif

   typedef struct {
      logic [1:0]  w;
      logic [31:0] a;
      logic        wr;
      logic [31:0] d;
      logic        e;
      logic [31:0] xd;
      logic        xf;
   } vec_t;

   logic        clk, reset_n;
   logic        req0, wr0, ext0, ack0, flt0;
   logic [1:0]  wid0;
   logic [31:0] addr0, dout0, din0;
   logic        req3, wr3, ext3, ack3, flt3;
   logic [1:0]  wid3;
   logic [31:0] addr3, dout3, din3;
   int          nchk, nerr;
   logic [7:0]  mb [16384];
   vec_t        tv [19];

   data_mem #(.ADDR_BITS(12), .WAIT_STATES(0)) u0 (
      .clk(clk), .reset_n(reset_n), .i_req(req0), .i_addr(addr0), .i_write(wr0),
      .i_data_out(dout0), .i_extend(ext0), .i_width(wid0),
      .o_ack(ack0), .o_data_in(din0), .o_fault(flt0)
   );

   data_mem #(.ADDR_BITS(12), .WAIT_STATES(3)) u3 (
      .clk(clk), .reset_n(reset_n), .i_req(req3), .i_addr(addr3), .i_write(wr3),
      .i_data_out(dout3), .i_extend(ext3), .i_width(wid3),
      .o_ack(ack3), .o_data_in(din3), .o_fault(flt3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", nerr);
      $fatal(1, "timeout");
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   task automatic acc0(input logic [1:0] w, input logic [31:0] a, input logic wr, input logic [31:0] d,
                       input logic e, output logic ack, output logic flt, output logic [31:0] din);
      @(negedge clk);
      req0 = 1'b1; wid0 = w; addr0 = a; wr0 = wr; dout0 = d; ext0 = e;
      #1 ack = ack0; flt = flt0;
      @(negedge clk);
      req0 = 1'b0;
      #1 din = din0;
   endtask

   task automatic acc3(input logic [1:0] w, input logic [31:0] a, input logic wr, input logic [31:0] d,
                       output int cyc, output logic [31:0] din);
      @(negedge clk);
      req3 = 1'b1; wid3 = w; addr3 = a; wr3 = wr; dout3 = d; ext3 = 1'b0;
      cyc = 1;
      #1;
      while (!ack3 && cyc < 12) begin
         @(negedge clk);
         cyc++;
         #1;
      end
      @(negedge clk);
      req3 = 1'b0;
      #1 din = din3;
   endtask

   // reference: byte-addressed little-endian memory, 14 byte-address bits
   task automatic model(input logic [1:0] w, input logic [31:0] a, input logic wr, input logic [31:0] d,
                        input logic e, inout logic [31:0] xd, output logic xf);
      int n, base;
      logic mis;
      logic [31:0] v;
      n    = (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
      mis  = (w == 2'd0) ? 1'b0 : (w == 2'd1) ? a[0] : (a[1:0] != 2'b00);
      base = int'(a[13:0]) & ~(n - 1);
      xf   = M & mis;
      if (!xf) begin
         if (wr) begin
            for (int k = 0; k < n; k++) mb[base + k] = d[8*k +: 8];
         end else begin
            v = 32'd0;
            for (int k = 0; k < n; k++) v = v | (32'(mb[base + k]) << (8 * k));
            if (e && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
            xd = v;
         end
      end
   endtask

   initial begin
      logic        a_ack, a_flt, x_flt;
      logic [31:0] a_din, x_din, ra, rd;
      logic [1:0]  rw;
      logic        rwr, re;
      int          cyc;
      nchk = 0; nerr = 0;
      reset_n = 1'b0;
      req0 = 0; wr0 = 0; ext0 = 0; wid0 = 0; addr0 = 0; dout0 = 0;
      req3 = 0; wr3 = 0; ext3 = 0; wid3 = 0; addr3 = 0; dout3 = 0;
      tv[0]  = '{2'd2, 32'h10,   1'b1, 32'hDEADBEEF, 1'b0, 32'h00000000, 1'b0};
      tv[1]  = '{2'd2, 32'h10,   1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0};
      tv[2]  = '{2'd0, 32'h13,   1'b1, 32'h00000080, 1'b0, 32'hDEADBEEF, 1'b0};
      tv[3]  = '{2'd0, 32'h13,   1'b0, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
      tv[4]  = '{2'd0, 32'h13,   1'b0, 32'h0,        1'b0, 32'h00000080, 1'b0};
      tv[5]  = '{2'd1, 32'h12,   1'b0, 32'h0,        1'b1, 32'hFFFF80AD, 1'b0};
      tv[6]  = '{2'd1, 32'h10,   1'b0, 32'h0,        1'b1, 32'hFFFFBEEF, 1'b0};
      tv[7]  = '{2'd2, 32'h4000, 1'b1, 32'h12345678, 1'b0, 32'hFFFFBEEF, 1'b0};
      tv[8]  = '{2'd2, 32'h0,    1'b0, 32'h0,        1'b0, 32'h12345678, 1'b0};
      tv[9]  = '{2'd1, 32'h2,    1'b1, 32'hDEADCAFE, 1'b0, 32'h12345678, 1'b0};
      tv[10] = '{2'd2, 32'h0,    1'b0, 32'h0,        1'b0, 32'hCAFE5678, 1'b0};
      tv[11] = '{2'd0, 32'h1,    1'b0, 32'h0,        1'b1, 32'h00000056, 1'b0};
      tv[12] = '{2'd2, 32'h20,   1'b1, 32'h55555555, 1'b0, 32'h00000056, 1'b0};
      tv[13] = '{2'd2, 32'h21,   1'b1, 32'h11223344, 1'b0, 32'h00000056, M};
      tv[14] = '{2'd2, 32'h20,   1'b0, 32'h0,        1'b0, M ? 32'h55555555 : 32'h11223344, 1'b0};
      tv[15] = '{2'd1, 32'h21,   1'b0, 32'h0,        1'b0, M ? 32'h55555555 : 32'h00003344, M};
      tv[16] = '{2'd3, 32'h20,   1'b0, 32'h0,        1'b1, M ? 32'h55555555 : 32'h11223344, 1'b0};
      tv[17] = '{2'd0, 32'h22,   1'b1, 32'h123456F0, 1'b0, M ? 32'h55555555 : 32'h11223344, 1'b0};
      tv[18] = '{2'd2, 32'h20,   1'b0, 32'h0,        1'b0, M ? 32'h55F05555 : 32'h11F03344, 1'b0};
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         chk("idle_ack0", 32'(ack0), 32'd0);
         chk("idle_ack3", 32'(ack3), 32'd0);
      end
      chk("rst_din0", din0, 32'd0);
      chk("rst_din3", din3, 32'd0);
      chk("rst_flt0", 32'(flt0), 32'd0);
      for (int i = 0; i < 19; i++) begin
         acc0(tv[i].w, tv[i].a, tv[i].wr, tv[i].d, tv[i].e, a_ack, a_flt, a_din);
         chk($sformatf("vec%0d_ack", i), 32'(a_ack), 32'd1);
         chk($sformatf("vec%0d_fault", i), 32'(a_flt), 32'(tv[i].xf));
         chk($sformatf("vec%0d_data", i), a_din, tv[i].xd);
      end
      @(negedge clk);
      req0 = 1'b1; wid0 = 2'd2; addr0 = 32'h30; wr0 = 1'b1; dout0 = 32'hA0B0C0D0;
      #1 chk("b2b_st_ack", 32'(ack0), 32'd1);
      @(negedge clk);
      wr0 = 1'b0;
      #1 chk("b2b_ld_ack", 32'(ack0), 32'd1);
      @(negedge clk);
      req0 = 1'b0;
      #1 chk("b2b_raw_data", din0, 32'hA0B0C0D0);
      x_din = 32'hA0B0C0D0;
      for (int k = 0; k < 16; k++) begin
         rd = $urandom;
         model(2'd2, 32'h100 + 32'(4 * k), 1'b1, rd, 1'b0, x_din, x_flt);
         acc0(2'd2, 32'h100 + 32'(4 * k), 1'b1, rd, 1'b0, a_ack, a_flt, a_din);
         chk("init_ack", 32'(a_ack), 32'd1);
      end
      for (int k = 0; k < 300; k++) begin
         rw  = 2'($urandom_range(0, 3));
         ra  = 32'h100 + 32'($urandom_range(0, 63)) + (32'($urandom_range(0, 3)) << 14);
         rwr = 1'($urandom_range(0, 1));
         rd  = $urandom;
         re  = 1'($urandom_range(0, 1));
         model(rw, ra, rwr, rd, re, x_din, x_flt);
         acc0(rw, ra, rwr, rd, re, a_ack, a_flt, a_din);
         chk($sformatf("rnd%0d_ack", k), 32'(a_ack), 32'd1);
         chk($sformatf("rnd%0d_fault w=%0d a=%h", k, rw, ra), 32'(a_flt), 32'(x_flt));
         chk($sformatf("rnd%0d_data w=%0d a=%h wr=%0d", k, rw, ra, rwr), a_din, x_din);
      end
      acc3(2'd2, 32'h40, 1'b1, 32'h0BADF00D, cyc, a_din);
      chk("ws3_st_cycle", 32'(cyc), 32'd4);
      chk("ws3_st_data", a_din, 32'd0);
      acc3(2'd2, 32'h40, 1'b0, 32'h0, cyc, a_din);
      chk("ws3_ld_cycle", 32'(cyc), 32'd4);
      chk("ws3_ld_data", a_din, 32'h0BADF00D);
      @(negedge clk);
      req3 = 1'b1; wid3 = 2'd2; addr3 = 32'h44; wr3 = 1'b0;
      #1 chk("drop_c1_ack", 32'(ack3), 32'd0);
      @(negedge clk);
      req3 = 1'b0;
      #1 chk("drop_c2_ack", 32'(ack3), 32'd0);
      @(negedge clk);
      #1 chk("drop_c3_ack", 32'(ack3), 32'd0);
      chk("drop_data", din3, 32'h0BADF00D);
      acc3(2'd2, 32'h40, 1'b0, 32'h0, cyc, a_din);
      chk("after_drop_cycle", 32'(cyc), 32'd4);
      @(negedge clk);
      req3 = 1'b1; wid3 = 2'd2; addr3 = 32'h40; wr3 = 1'b1; dout3 = 32'hFFFFFFFF;
      #1 chk("rst_wait_c1_ack", 32'(ack3), 32'd0);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("rst_mid_din3", din3, 32'd0);
      chk("rst_mid_din0", din0, 32'd0);
      chk("rst_wait_c3_ack", 32'(ack3), 32'd0);
      @(negedge clk);
      #1 chk("rst_wait_c4_ack", 32'(ack3), 32'd0);
      @(negedge clk);
      req3 = 1'b0;
      acc3(2'd2, 32'h40, 1'b0, 32'h0, cyc, a_din);
      chk("rst_mid_cycle", 32'(cyc), 32'd4);
      chk("rst_mid_mem", a_din, 32'h0BADF00D);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/data_mem.md
# data_mem

Data-memory responder on the load/store request/acknowledge interface driven by the pipeline's memory stage. It accepts one byte, halfword or word access per request and inserts a configurable number of wait states. Writes are applied with byte-lane enables; read data is aligned and zero- or sign-extended. Backing storage is an internal word array, and the block sits between the memory stage and writeback as the single data-side target.

## Interface
- `ADDR_BITS`, default 12: word-address bits; capacity is 2^ADDR_BITS words.
- `WAIT_STATES`, default 0: extra cycles before `ack` (0–15).
- `clk`  in  1  clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `req`  in  1  access request; held until `ack`.
- `addr`  in  32  byte address.
- `write`  in  1  1 = store, 0 = load.
- `data_out`  in  32  store data, right-justified.
- `extend`  in  1  1 = sign-extend load, 0 = zero-extend.
- `width`  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- `ack`  out  1  access completes this cycle.
- `data_in`  out  32  load result, registered.
- `fault`  out  1  misaligned-access pulse, coincident with `ack` (macro-dependent).

## Operation
- FSM states are IDLE and WAIT.
  - IDLE with `req`: if `WAIT_STATES`==0, `ack`=1 this cycle. Otherwise go to WAIT and set cnt=`WAIT_STATES`-1.
  - WAIT with `req`: if cnt==0, `ack`=1 and go to IDLE. Otherwise decrement cnt.
  - WAIT with `req` low: abandon the access, go to IDLE, no side effects.
- The access executes at the rising edge ending the `ack` cycle.
  - Store: write the addressed word with lane enables. Byte uses lane `addr[1:0]`; half uses lanes {`addr[1]`,0} pair; word uses all lanes. Data is replicated into lanes as `data_out[7:0]` or `data_out[15:0]`.
  - Load: extract the byte or half at the lane, extend per `extend`, and register it into `data_in`.
- `data_in` holds its value until the next completed load. Stores do not change it.
- Word index is `addr[ADDR_BITS+1:2]`. Upper address bits are ignored, so addresses wrap modulo capacity.
- Byte order is little-endian.
- `ack` is never asserted without `req`.
- Request fields must be stable while `req`=1 and `ack`=0. Sampling uses ack-cycle values only.

## Timing
- Reset values: `ack`=0, `data_in`=0, `fault`=0, FSM=IDLE, cnt=0. Array contents are not reset.
- Latency: `ack` is asserted in cycle `WAIT_STATES`+1 of `req`.
  - With `WAIT_STATES`=0, `ack` is combinational from `req` in IDLE.
- Load data is valid on `data_in` the cycle after `ack`, which is when writeback samples it.
- Back-to-back: after the `ack` cycle the FSM is in IDLE. A `req` high in the next cycle is a new access.
  - At 0 wait states, one access completes per cycle.
- Read-after-write to the same word in consecutive accesses returns the new data. No bypass is needed because the write commits before the read's `ack` edge.
- Reset asserted mid-WAIT: the FSM returns to IDLE, the access is dropped, and nothing is written.

## Configuration
- `DMEM_MISALIGN_CHECK_EN` defined:
  - A half access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, still completes normally with `ack`.
  - `fault`=1 in the `ack` cycle.
  - A misaligned store writes nothing.
  - A misaligned load leaves `data_in` unchanged.
- Not defined:
  - Misaligned low bits are masked: half ignores `addr[0]`; word ignores `addr[1:0]`.
  - `fault` is tied to 0.

## Structure
- Package `dmem_pkg` holds:
  - width encodings `WIDTH_B`=2'b00, `WIDTH_H`=2'b01, `WIDTH_W`=2'b10;
  - the FSM state typedef {`ST_IDLE`, `ST_WAIT`};
  - the misalignment check function.
- Sub-module `dmem_align` (combinational) holds lane-enable generation, store-data replication, and load extraction/extension.
- `data_mem` holds the FSM, the wait counter, the array, and the `data_in` register.

## Test plan
- Reset, then idle: `ack`=0, `data_in`=0, `fault`=0. No `ack` while `req`=0.
- `WAIT_STATES`=0: store word 0xDEADBEEF @0x10, then load word @0x10. Expect `ack` in the same cycle as each `req`, and `data_in`=0xDEADBEEF one cycle after the load `ack`.
- Byte/half lanes: store byte 0x80 @0x13, then:
  - load byte sign-extended @0x13 → 0xFFFFFF80;
  - load byte zero-extended → 0x00000080;
  - load half signed @0x12 → 0xFFFF80AD.
- `WAIT_STATES`=3: hold `req` for a load. Expect `ack` only in the 4th cycle. Dropping `req` in cycle 2 returns the FSM to IDLE with `data_in` unchanged.
- Wrap-around with `ADDR_BITS`=12: store @0x4000 and load @0x0000 → same data. Reset asserted mid-WAIT of a store → the word is unchanged.
- With `DMEM_MISALIGN_CHECK_EN`: store word @0x21 → `ack`=1 and `fault`=1, memory unchanged. Without the macro: the same store writes the word @0x20 and `fault`=0.
